// File: rtl/fc_param_mem_pkg.sv
// Shared encodings for the FC parameter store: config bank map, weight count,
// stream FSM states and the load-result source select.
package fc_param_mem_pkg;
  localparam int FC_NUM_WEIGHTS = 208;

  localparam logic [1:0] FC_BANK_W0 = 2'd0;
  localparam logic [1:0] FC_BANK_W1 = 2'd1;
  localparam logic [1:0] FC_BANK_B0 = 2'd2;
  localparam logic [1:0] FC_BANK_B1 = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} fc_state_e;
  typedef enum logic [1:0] {RD_ZERO, RD_W0, RD_W1, RD_BIAS} fc_rd_sel_e;
endpackage

// File: rtl/fc_weight_bank.sv
// One weight array: guarded write, stream read port A, config read port B.
// Both read ports are registered and only update when enabled.
module fc_weight_bank #(
  parameter int ADDR_BW     = 8,
  parameter int IDX_BW      = 8,
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_WEIGHTS = 208
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BW-1:0]   wr_addr_i,
  input  logic [WEIGHT_BW-1:0] wr_data_i,
  input  logic                 a_en_i,
  input  logic [IDX_BW-1:0]    a_addr_i,
  output logic [WEIGHT_BW-1:0] a_data_o,
  input  logic                 b_en_i,
  input  logic [ADDR_BW-1:0]   b_addr_i,
  output logic [WEIGHT_BW-1:0] b_data_o
);
  logic [WEIGHT_BW-1:0] r_mem [NUM_WEIGHTS];
  logic [WEIGHT_BW-1:0] r_a_data, r_b_data;

  // Array contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (wr_addr_i < ADDR_BW'(NUM_WEIGHTS)))
      r_mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      if (a_en_i) r_a_data <= r_mem[a_addr_i];
      if (b_en_i) r_b_data <= r_mem[b_addr_i];
    end
  end

  assign a_data_o = r_a_data;
  assign b_data_o = r_b_data;
endmodule

// File: rtl/fc_param_mem.sv
// FC layer parameter store: config loads/stores of two weight banks and two
// biases, plus a lock-step valid/ready stream of both weight banks.
module fc_param_mem
  import fc_param_mem_pkg::*;
#(
  parameter int BANK_BW     = 2,
  parameter int ADDR_BW     = 8,
  parameter int BIAS_BW     = 32,
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_WEIGHTS = FC_NUM_WEIGHTS
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  input  logic [BANK_BW-1:0]   rd_wr_bank_i,
  input  logic [ADDR_BW-1:0]   rd_wr_addr_i,
  input  logic [BIAS_BW-1:0]   wr_data_i,
  output logic [BIAS_BW-1:0]   rd_data_o,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WEIGHT_BW-1:0] weight0_o,
  output logic [WEIGHT_BW-1:0] weight1_o,
  output logic                 last_o,
  output logic [BIAS_BW-1:0]   bias0_o,
  output logic [BIAS_BW-1:0]   bias1_o,
  output logic                 cfg_conflict_o
);
  localparam int IDX_BW = $clog2(NUM_WEIGHTS);

  fc_state_e            r_state, w_nxt_state;
  logic [IDX_BW-1:0]    r_idx, w_fetch_idx;
  logic                 r_busy, r_valid, r_last, r_conflict;
  logic                 w_fetch, w_start, w_done, w_store, w_rd_inrange;
  logic [BIAS_BW-1:0]   r_bias0, r_bias1, r_rd_bias;
  fc_rd_sel_e           r_rd_sel;
  logic [1:0][WEIGHT_BW-1:0] w_a_data, w_b_data;

  assign w_store      = wr_en_i && !r_busy;
  assign w_rd_inrange = rd_wr_addr_i < ADDR_BW'(NUM_WEIGHTS);
  assign w_start      = (r_state == ST_IDLE) && start_i;
  assign w_done       = (r_state == ST_RUN) && r_valid && ready_i && r_last;

  // Stream owns port A so a stalled beat never changes; config loads use port B.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fc_weight_bank #(
      .ADDR_BW(ADDR_BW), .IDX_BW(IDX_BW),
      .WEIGHT_BW(WEIGHT_BW), .NUM_WEIGHTS(NUM_WEIGHTS)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .wr_en_i  (w_store && (rd_wr_bank_i == BANK_BW'(b))),
      .wr_addr_i(rd_wr_addr_i),
      .wr_data_i(wr_data_i[WEIGHT_BW-1:0]),
      .a_en_i   (w_fetch),
      .a_addr_i (w_fetch_idx),
      .a_data_o (w_a_data[b]),
      .b_en_i   (rd_en_i && w_rd_inrange && (rd_wr_bank_i == BANK_BW'(b))),
      .b_addr_i (rd_wr_addr_i),
      .b_data_o (w_b_data[b])
    );
  end

  always_comb begin
    w_nxt_state = r_state;
    w_fetch     = 1'b0;
    w_fetch_idx = r_idx;
    case (r_state)
      ST_IDLE: if (start_i) w_nxt_state = ST_LOAD;
      ST_LOAD: begin
        w_fetch     = 1'b1;
        w_nxt_state = ST_RUN;
      end
      ST_RUN: if (r_valid && ready_i) begin
        if (r_last) w_nxt_state = ST_IDLE;
        else begin
          w_fetch     = 1'b1;
          w_fetch_idx = r_idx + 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (w_start) begin
        r_idx  <= '0;
        r_busy <= 1'b1;
      end else if (w_done) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_fetch) begin
        r_idx   <= w_fetch_idx;
        r_valid <= 1'b1;
        r_last  <= (w_fetch_idx == IDX_BW'(NUM_WEIGHTS - 1));
      end
      if (w_start)                 r_conflict <= 1'b0;
      else if (wr_en_i && r_busy)  r_conflict <= 1'b1;
    end
  end

  // Bias loads snapshot the register so the result holds even if bias changes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bias0   <= '0;
      r_bias1   <= '0;
      r_rd_bias <= '0;
      r_rd_sel  <= RD_ZERO;
    end else begin
      if (w_store && rd_wr_bank_i == FC_BANK_B0) r_bias0 <= wr_data_i;
      if (w_store && rd_wr_bank_i == FC_BANK_B1) r_bias1 <= wr_data_i;
      if (rd_en_i) begin
        case (rd_wr_bank_i)
          FC_BANK_W0: r_rd_sel <= w_rd_inrange ? RD_W0 : RD_ZERO;
          FC_BANK_W1: r_rd_sel <= w_rd_inrange ? RD_W1 : RD_ZERO;
          FC_BANK_B0: begin
            r_rd_sel  <= RD_BIAS;
            r_rd_bias <= r_bias0;
          end
          default: begin
            r_rd_sel  <= RD_BIAS;
            r_rd_bias <= r_bias1;
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (r_rd_sel)
      RD_W0:   rd_data_o = {{(BIAS_BW-WEIGHT_BW){w_b_data[0][WEIGHT_BW-1]}}, w_b_data[0]};
      RD_W1:   rd_data_o = {{(BIAS_BW-WEIGHT_BW){w_b_data[1][WEIGHT_BW-1]}}, w_b_data[1]};
      RD_BIAS: rd_data_o = r_rd_bias;
      default: rd_data_o = '0;
    endcase
  end

  assign busy_o         = r_busy;
  assign valid_o        = r_valid;
  assign last_o         = r_last;
  assign weight0_o      = w_a_data[0];
  assign weight1_o      = w_a_data[1];
  assign bias0_o        = r_bias0;
  assign bias1_o        = r_bias1;
  assign cfg_conflict_o = r_conflict;
endmodule
